rm_event_seq_detector: RTL and testbench
========================================

RM_EVENT_SEQ_DETECTOR -- requirements
Module: rm_event_seq_detector

Interface
REQ-001 SHALL have parameter NUM_VARS, default 10, number of single-bit probed variables.
REQ-002 SHALL have parameter NUM_LANES, default 5, number of independent monitor lanes; LW = $clog2(NUM_LANES).
REQ-003 SHALL have parameter LEAF_EVENT, default 0; 1 = block is a leaf and requests lane reset on every monitored instruction.
REQ-004 SHALL have parameter CNT_W, default 8, width of hit/window counters.
REQ-005 SHALL have ports: clk_i in 1 clock; rst_ni in 1 reset, asynchronous, active-low.
REQ-006 SHALL have ports: signal_i in NUM_VARS probed values; ref_val_i in NUM_VARS reference values; mask_i in NUM_VARS compare enable per bit (1 = compare).
REQ-007 SHALL have ports: monitor_ins_i in 1 instruction under monitor; lane_i in LW target lane; reset_lane_i in 1 upstream lane reset.
REQ-008 SHALL have ports: threshold_i in CNT_W hits required to fire; window_i in CNT_W cycle timeout, 0 = disabled.
REQ-009 SHALL have ports: probe_val_o out 1 registered match; lane_o out LW registered lane; reset_lane_o out 1 registered lane reset; event_o out 1 fire pulse; hit_count_o out CNT_W hit count of lane_o lane.

Function
REQ-010 match SHALL = monitor_ins_i AND (for all i: mask_i[i]=0 OR signal_i[i]=ref_val_i[i]); mask_i all zero with monitor_ins_i=1 -> match=1.
REQ-011 lane_i >= NUM_LANES SHALL be invalid: match forced 0, no lane state change.
REQ-012 probe_val_o, lane_o SHALL present match and lane_i with exactly 1 cycle latency.
REQ-013 reset_lane_o SHALL register (LEAF_EVENT && monitor_ins_i) ? 1 : reset_lane_i, 1 cycle latency.
REQ-014 Each lane SHALL hold state {IDLE, ARMED}, hit counter, window counter.
REQ-015 IDLE + match: hit=1; if effective threshold (threshold_i, 0 treated as 1) <= 1 -> fire, stay IDLE, hit=0; else -> ARMED, window counter=0.
REQ-016 ARMED + match: hit+1; if hit+1 >= effective threshold -> fire, -> IDLE, hit=0.
REQ-017 ARMED each cycle without match SHALL increment window counter; counter reaching window_i (non-zero) -> IDLE, hit=0, no fire.
REQ-018 Match and window expiry same cycle: match wins (counted, window counter restarts at 0).
REQ-019 Fire SHALL drive event_o=1 for exactly one cycle, the cycle after the firing match, aligned with probe_val_o=1.
REQ-020 reset_lane_i=1 SHALL clear lane lane_i to IDLE, hit=0, taking priority over a same-cycle match on that lane (no fire, probe_val_o still reflects match).
REQ-021 Counters SHALL saturate at 2^CNT_W-1, never wrap.
REQ-022 hit_count_o SHALL show the post-update hit count of the lane on lane_o; 0 after fire or clear.
REQ-023 Lanes other than lane_i SHALL only advance window counters.

Reset
REQ-024 rst_ni low SHALL asynchronously force all lanes IDLE, all counters 0, probe_val_o=0, lane_o=0, reset_lane_o=0, event_o=0, hit_count_o=0.
REQ-025 Reset asserted mid-sequence SHALL discard partial hit counts; first cycle after release behaves as fresh IDLE.

Configuration
REQ-026 Macro RM_EVT_WINDOW_EN defined: window counters and timeout (REQ-017/018) compiled in.
REQ-027 RM_EVT_WINDOW_EN undefined: no window counters, window_i ignored, ARMED lanes wait indefinitely; all other behaviour identical.

Verification
REQ-028 threshold_i=3, window_i=0, three matches on lane 2 in cycles 1,4,9 -> event_o=1 only in cycle 10, hit_count_o 1,2,0.
REQ-029 mask_i=0x3FF, ref_val_i=0x155, signal_i=0x154, monitor_ins_i=1 -> probe_val_o=0; mask_i=0x3FE same inputs -> probe_val_o=1 next cycle.
REQ-030 RM_EVT_WINDOW_EN, threshold_i=2, window_i=4, match cycle 0, no match cycles 1-4 -> lane IDLE, match cycle 6 gives hit_count_o=1, no event.
REQ-031 threshold_i=2, lane 1 ARMED, reset_lane_i=1 with match on lane 1 -> no event_o, hit_count_o=0, probe_val_o=1.
REQ-032 LEAF_EVENT=1, monitor_ins_i=1, reset_lane_i=0 -> reset_lane_o=1 next cycle; lane_i=7 (NUM_LANES=5) -> probe_val_o=0, no state change.
REQ-033 rst_ni low for 1 cycle while lane 0 hit=2 of threshold 3 -> all outputs 0; next match yields hit_count_o=1, no event.

Source files
------------

// File: rtl/rm_event_seq_detector.sv
// rtl/rm_event_seq_detector.sv - multi-lane event sequence detector; window timeout compiled in with RM_EVT_WINDOW_EN
module rm_event_seq_detector #(
  parameter int NUM_VARS   = 10,
  parameter int NUM_LANES  = 5,
  parameter int LEAF_EVENT = 0,
  parameter int CNT_W      = 8,
  localparam int LW        = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NUM_VARS-1:0] signal_i,
  input  logic [NUM_VARS-1:0] ref_val_i,
  input  logic [NUM_VARS-1:0] mask_i,
  input  logic                monitor_ins_i,
  input  logic [LW-1:0]       lane_i,
  input  logic                reset_lane_i,
  input  logic [CNT_W-1:0]    threshold_i,
  input  logic [CNT_W-1:0]    window_i,
  output logic                probe_val_o,
  output logic [LW-1:0]       lane_o,
  output logic                reset_lane_o,
  output logic                event_o,
  output logic [CNT_W-1:0]    hit_count_o
);

  typedef enum logic {ST_IDLE = 1'b0, ST_ARMED = 1'b1} lane_state_e;

  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [LW:0]      NUM_LANES_W = (LW + 1)'(NUM_LANES);

  lane_state_e      r_state     [NUM_LANES];
  logic [CNT_W-1:0] r_hit       [NUM_LANES];
  lane_state_e      w_state_nxt [NUM_LANES];
  logic [CNT_W-1:0] w_hit_nxt   [NUM_LANES];
`ifdef RM_EVT_WINDOW_EN
  logic [CNT_W-1:0] r_win       [NUM_LANES];
  logic [CNT_W-1:0] w_win_nxt   [NUM_LANES];
`else
  logic             w_unused_window;
  assign w_unused_window = ^window_i;
`endif

  logic             w_lane_ok;
  logic             w_match;
  logic             w_fire;
  logic [CNT_W-1:0] w_thr;
  logic [CNT_W-1:0] w_hit_out;

  logic             r_probe;
  logic [LW-1:0]    r_lane;
  logic             r_reset_lane;
  logic             r_event;
  logic [CNT_W-1:0] r_hit_count;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? CNT_MAX : v + CNT_ONE;
  endfunction

  // Qualify the probe: valid lane, instruction present, every enabled bit equal to its reference
  always_comb begin
    w_lane_ok = ({1'b0, lane_i} < NUM_LANES_W);
    w_match   = monitor_ins_i & w_lane_ok & (&(~mask_i | ~(signal_i ^ ref_val_i)));
    w_thr     = (threshold_i == '0) ? CNT_ONE : threshold_i;
  end

  // Per-lane next state: lane clear beats match, match beats window expiry
  always_comb begin
    w_fire    = 1'b0;
    w_hit_out = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      w_state_nxt[l] = r_state[l];
      w_hit_nxt[l]   = r_hit[l];
`ifdef RM_EVT_WINDOW_EN
      w_win_nxt[l]   = r_win[l];
`endif
      if (w_lane_ok && (lane_i == LW'(l)) && reset_lane_i) begin
        w_state_nxt[l] = ST_IDLE;
        w_hit_nxt[l]   = '0;
`ifdef RM_EVT_WINDOW_EN
        w_win_nxt[l]   = '0;
`endif
      end else if (w_lane_ok && (lane_i == LW'(l)) && w_match) begin
        if (r_state[l] == ST_IDLE) begin
          if (w_thr == CNT_ONE) begin
            w_fire       = 1'b1;
            w_hit_nxt[l] = '0;
          end else begin
            w_state_nxt[l] = ST_ARMED;
            w_hit_nxt[l]   = CNT_ONE;
          end
        end else if (sat_inc(r_hit[l]) >= w_thr) begin
          w_fire         = 1'b1;
          w_state_nxt[l] = ST_IDLE;
          w_hit_nxt[l]   = '0;
        end else begin
          w_hit_nxt[l] = sat_inc(r_hit[l]);
        end
`ifdef RM_EVT_WINDOW_EN
        w_win_nxt[l] = '0;
`endif
      end else if (r_state[l] == ST_ARMED) begin
`ifdef RM_EVT_WINDOW_EN
        if ((window_i != '0) && (sat_inc(r_win[l]) >= window_i)) begin
          w_state_nxt[l] = ST_IDLE;
          w_hit_nxt[l]   = '0;
          w_win_nxt[l]   = '0;
        end else begin
          w_win_nxt[l] = sat_inc(r_win[l]);
        end
`endif
      end
      if (w_lane_ok && (lane_i == LW'(l))) begin
        w_hit_out = w_hit_nxt[l];
      end
    end
  end

  // Lane state and counters
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        r_state[l] <= ST_IDLE;
        r_hit[l]   <= '0;
`ifdef RM_EVT_WINDOW_EN
        r_win[l]   <= '0;
`endif
      end
    end else begin
      for (int l = 0; l < NUM_LANES; l++) begin
        r_state[l] <= w_state_nxt[l];
        r_hit[l]   <= w_hit_nxt[l];
`ifdef RM_EVT_WINDOW_EN
        r_win[l]   <= w_win_nxt[l];
`endif
      end
    end
  end

  // Registered outputs, all one cycle behind the probed instruction
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_probe      <= 1'b0;
      r_lane       <= '0;
      r_reset_lane <= 1'b0;
      r_event      <= 1'b0;
      r_hit_count  <= '0;
    end else begin
      r_probe      <= w_match;
      r_lane       <= lane_i;
      r_reset_lane <= ((LEAF_EVENT != 0) && monitor_ins_i) ? 1'b1 : reset_lane_i;
      r_event      <= w_fire;
      r_hit_count  <= w_hit_out;
    end
  end

  assign probe_val_o  = r_probe;
  assign lane_o       = r_lane;
  assign reset_lane_o = r_reset_lane;
  assign event_o      = r_event;
  assign hit_count_o  = r_hit_count;

endmodule

// File: tb/tb_rm_event_seq_detector.sv
// tb/tb_rm_event_seq_detector.sv - directed self-checking bench for rm_event_seq_detector
module tb_rm_event_seq_detector;
  localparam int NV = 10;
  localparam int NL = 5;
  localparam int CW = 8;
  localparam int LW = 3;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [NV-1:0] signal_i, ref_val_i, mask_i;
  logic          monitor_ins_i;
  logic [LW-1:0] lane_i;
  logic          reset_lane_i;
  logic [CW-1:0] threshold_i, window_i;
  logic          probe_val_o, reset_lane_o, event_o;
  logic [LW-1:0] lane_o;
  logic [CW-1:0] hit_count_o;
  logic          leaf_probe, leaf_reset_lane, leaf_event;
  logic [LW-1:0] leaf_lane;
  logic [CW-1:0] leaf_hit;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  rm_event_seq_detector #(.NUM_VARS(NV), .NUM_LANES(NL), .LEAF_EVENT(0), .CNT_W(CW)) u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .signal_i(signal_i), .ref_val_i(ref_val_i), .mask_i(mask_i),
    .monitor_ins_i(monitor_ins_i), .lane_i(lane_i), .reset_lane_i(reset_lane_i),
    .threshold_i(threshold_i), .window_i(window_i), .probe_val_o(probe_val_o), .lane_o(lane_o),
    .reset_lane_o(reset_lane_o), .event_o(event_o), .hit_count_o(hit_count_o)
  );

  rm_event_seq_detector #(.NUM_VARS(NV), .NUM_LANES(NL), .LEAF_EVENT(1), .CNT_W(CW)) u_leaf (
    .clk_i(clk_i), .rst_ni(rst_ni), .signal_i(signal_i), .ref_val_i(ref_val_i), .mask_i(mask_i),
    .monitor_ins_i(monitor_ins_i), .lane_i(lane_i), .reset_lane_i(reset_lane_i),
    .threshold_i(threshold_i), .window_i(window_i), .probe_val_o(leaf_probe), .lane_o(leaf_lane),
    .reset_lane_o(leaf_reset_lane), .event_o(leaf_event), .hit_count_o(leaf_hit)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic outs(input string tag, input logic probe, input logic [LW-1:0] ln,
                      input logic ev, input logic [CW-1:0] hit);
    chk({tag, ".probe"}, 32'(probe_val_o), 32'(probe));
    chk({tag, ".lane"},  32'(lane_o),      32'(ln));
    chk({tag, ".event"}, 32'(event_o),     32'(ev));
    chk({tag, ".hit"},   32'(hit_count_o), 32'(hit));
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic go(input logic mon, input logic [LW-1:0] ln, input logic rl);
    monitor_ins_i = mon;
    lane_i        = ln;
    reset_lane_i  = rl;
    step();
  endtask

  initial begin
    rst_ni = 1'b0; signal_i = '0; ref_val_i = '0; mask_i = '0;
    monitor_ins_i = 1'b0; lane_i = '0; reset_lane_i = 1'b0;
    threshold_i = 8'd3; window_i = 8'd0;
    step();
    step();
    outs("rst", 1'b0, 3'd0, 1'b0, 8'd0);
    chk("rst.rl", 32'(reset_lane_o), 32'd0);
    rst_ni = 1'b1;

    // threshold 3, matches on lane 2 at cycles 1, 4, 9
    go(1'b1, 3'd2, 1'b0); outs("a1", 1'b1, 3'd2, 1'b0, 8'd1);
    go(1'b0, 3'd2, 1'b0); outs("a2", 1'b0, 3'd2, 1'b0, 8'd1);
    go(1'b0, 3'd2, 1'b0);
    go(1'b1, 3'd2, 1'b0); outs("a4", 1'b1, 3'd2, 1'b0, 8'd2);
    for (int i = 0; i < 4; i++) begin
      go(1'b0, 3'd2, 1'b0);
      chk("a_gap.event", 32'(event_o), 32'd0);
    end
    go(1'b1, 3'd2, 1'b0); outs("a9", 1'b1, 3'd2, 1'b1, 8'd0);
    go(1'b0, 3'd2, 1'b0); outs("a10", 1'b0, 3'd2, 1'b0, 8'd0);

    // mask compare, threshold 1 and threshold 0
    threshold_i = 8'd1; mask_i = 10'h3FF; ref_val_i = 10'h155; signal_i = 10'h154;
    go(1'b1, 3'd0, 1'b0); outs("b1", 1'b0, 3'd0, 1'b0, 8'd0);
    mask_i = 10'h3FE;
    go(1'b1, 3'd0, 1'b0); outs("b2", 1'b1, 3'd0, 1'b1, 8'd0);
    threshold_i = 8'd0; mask_i = 10'h000;
    go(1'b1, 3'd0, 1'b0); outs("b3", 1'b1, 3'd0, 1'b1, 8'd0);
    go(1'b0, 3'd0, 1'b0); outs("b4", 1'b0, 3'd0, 1'b0, 8'd0);

    // lane clear beats same-cycle match
    threshold_i = 8'd2;
    go(1'b1, 3'd1, 1'b0); outs("c1", 1'b1, 3'd1, 1'b0, 8'd1);
    go(1'b1, 3'd1, 1'b1); outs("c2", 1'b1, 3'd1, 1'b0, 8'd0);
    chk("c2.rl", 32'(reset_lane_o), 32'd1);
    go(1'b1, 3'd1, 1'b0); outs("c3", 1'b1, 3'd1, 1'b0, 8'd1);
    chk("c3.rl", 32'(reset_lane_o), 32'd0);
    go(1'b1, 3'd1, 1'b0); outs("c4", 1'b1, 3'd1, 1'b1, 8'd0);

    // invalid lane, leaf reset request, lane independence
    go(1'b1, 3'd3, 1'b0); outs("d1", 1'b1, 3'd3, 1'b0, 8'd1);
    go(1'b1, 3'd7, 1'b1); outs("d2", 1'b0, 3'd7, 1'b0, 8'd0);
    chk("d2.rl", 32'(reset_lane_o), 32'd1);
    chk("d2.leaf_probe", 32'(leaf_probe), 32'd0);
    go(1'b0, 3'd0, 1'b0);
    chk("d3.rl", 32'(reset_lane_o), 32'd0);
    chk("d3.leaf_rl", 32'(leaf_reset_lane), 32'd0);
    go(1'b1, 3'd0, 1'b0); outs("d4", 1'b1, 3'd0, 1'b0, 8'd1);
    chk("d4.rl", 32'(reset_lane_o), 32'd0);
    chk("d4.leaf_rl", 32'(leaf_reset_lane), 32'd1);
    go(1'b1, 3'd3, 1'b0); outs("d5", 1'b1, 3'd3, 1'b1, 8'd0);
    go(1'b1, 3'd0, 1'b0); outs("d6", 1'b1, 3'd0, 1'b1, 8'd0);

    // window timeout behaviour
    threshold_i = 8'd2; window_i = 8'd4;
`ifdef RM_EVT_WINDOW_EN
    go(1'b1, 3'd2, 1'b0); outs("f0", 1'b1, 3'd2, 1'b0, 8'd1);
    for (int i = 0; i < 5; i++) go(1'b0, 3'd2, 1'b0);
    go(1'b1, 3'd2, 1'b0); outs("f6", 1'b1, 3'd2, 1'b0, 8'd1);
    for (int i = 0; i < 3; i++) go(1'b0, 3'd2, 1'b0);
    go(1'b1, 3'd2, 1'b0); outs("f_race", 1'b1, 3'd2, 1'b1, 8'd0);
`else
    go(1'b1, 3'd2, 1'b0); outs("f0", 1'b1, 3'd2, 1'b0, 8'd1);
    for (int i = 0; i < 8; i++) go(1'b0, 3'd2, 1'b0);
    go(1'b1, 3'd2, 1'b0); outs("f_wait", 1'b1, 3'd2, 1'b1, 8'd0);
`endif
    window_i = 8'd0;

    // asynchronous reset mid-sequence
    threshold_i = 8'd3;
    go(1'b1, 3'd0, 1'b0);
    go(1'b1, 3'd0, 1'b0); outs("e2", 1'b1, 3'd0, 1'b0, 8'd2);
    monitor_ins_i = 1'b0;
    #3 rst_ni = 1'b0;
    #1 outs("e_rst", 1'b0, 3'd0, 1'b0, 8'd0);
    step();
    rst_ni = 1'b1;
    go(1'b1, 3'd0, 1'b0); outs("e_after", 1'b1, 3'd0, 1'b0, 8'd1);
    go(1'b1, 3'd0, 1'b0); outs("e_next", 1'b1, 3'd0, 1'b0, 8'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
